// File: rtl/game_tick_scheduler.sv
// Game-loop timebase: divides clk_in into a base tick, shares it among the scroll,
// gravity, flap and spawn consumers, and sequences IDLE/RUN/PAUSED/OVER with score-driven speed-up.
module game_tick_scheduler #(
    parameter int BASE_CYCLE = 762,
    parameter int LEVEL_STEP = 64,
    parameter int MAX_LEVEL  = 7,
    parameter int LVL_SCORE  = 5,
    parameter int GRAV_DIV   = 2,
    parameter int SPAWN_DIV  = 8
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       start,
    input  logic       flap,
    input  logic       hit,
    input  logic       point,
    input  logic       pause,
    output logic [1:0] state,
    output logic       scroll_tick,
    output logic       gravity_tick,
    output logic       flap_tick,
    output logic       spawn_tick,
    output logic [2:0] level
);

    localparam int CW = (BASE_CYCLE > 1) ? $clog2(BASE_CYCLE) : 1;
    localparam int PW = (LVL_SCORE  > 1) ? $clog2(LVL_SCORE)  : 1;
    localparam int GW = (GRAV_DIV   > 1) ? $clog2(GRAV_DIV)   : 1;
    localparam int SW = (SPAWN_DIV  > 1) ? $clog2(SPAWN_DIV)  : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      level_q, level_d;
    logic [PW-1:0]   pts_q, pts_d;
    logic [GW-1:0]   grav_q, grav_d;
    logic [SW-1:0]   spawn_q, spawn_d;
    logic            pend_q, pend_d;
    logic            scroll_q, scroll_d;
    logic            gtick_q, gtick_d;
    logic            ftick_q, ftick_d;
    logic            stick_q, stick_d;

    logic            in_run;
    logic            advance;
    logic            issue;
    logic            grav_slot;
    logic [CW-1:0]   reload_val;

    // Reload value follows the level currently held, so a mid-period level change waits for the next reload.
    assign reload_val = CW'(BASE_CYCLE - 1 - int'(level_q) * LEVEL_STEP);

    assign in_run    = (state_q == ST_RUN);
    assign advance   = in_run && !hit && !pause;
    assign issue     = advance && (cnt_q == '0);
    assign grav_slot = (grav_q == GW'(GRAV_DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        pts_d    = pts_q;
        grav_d   = grav_q;
        spawn_d  = spawn_q;
        pend_d   = pend_q;
        scroll_d = 1'b0;
        gtick_d  = 1'b0;
        ftick_d  = 1'b0;
        stick_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = CW'(BASE_CYCLE - 1);
                    level_d = '0;
                    pts_d   = '0;
                    grav_d  = '0;
                    spawn_d = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (hit) begin
                    state_d = ST_OVER;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            cnt_d    = reload_val;
            scroll_d = 1'b1;
            grav_d   = grav_slot ? '0 : grav_q + GW'(1);
            spawn_d  = (spawn_q == SW'(SPAWN_DIV - 1)) ? '0 : spawn_q + SW'(1);
            stick_d  = (spawn_q == SW'(SPAWN_DIV - 1));
            // A flap takes the slot; a gravity slot lost this way is not carried forward.
            if (pend_q || flap) begin
                ftick_d = 1'b1;
                pend_d  = 1'b0;
            end else begin
                gtick_d = grav_slot;
            end
        end else begin
            if (advance) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (in_run && flap) begin
                pend_d = 1'b1;
            end
        end

        if (in_run && !hit && point) begin
            if (pts_q == PW'(LVL_SCORE - 1)) begin
                pts_d = '0;
                if (level_q != 3'(MAX_LEVEL)) begin
                    level_d = level_q + 3'd1;
                end
            end else begin
                pts_d = pts_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            pts_q    <= '0;
            grav_q   <= '0;
            spawn_q  <= '0;
            pend_q   <= 1'b0;
            scroll_q <= 1'b0;
            gtick_q  <= 1'b0;
            ftick_q  <= 1'b0;
            stick_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pts_q    <= pts_d;
            grav_q   <= grav_d;
            spawn_q  <= spawn_d;
            pend_q   <= pend_d;
            scroll_q <= scroll_d;
            gtick_q  <= gtick_d;
            ftick_q  <= ftick_d;
            stick_q  <= stick_d;
        end
    end

    assign state        = state_q;
    assign level        = level_q;
    assign scroll_tick  = scroll_q;
    assign gravity_tick = gtick_q;
    assign flap_tick    = ftick_q;
    assign spawn_tick   = stick_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: a score/tick-count model checked every cycle,
// plus hand-computed pulse positions for each scenario.
module tb_game_tick_scheduler;

    localparam int BC  = 10;
    localparam int LS  = 2;
    localparam int ML  = 3;
    localparam int LSC = 2;
    localparam int GD  = 2;
    localparam int SD  = 3;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       start = 1'b0;
    logic       flap  = 1'b0;
    logic       hit   = 1'b0;
    logic       point = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] state;
    logic       scroll_tick;
    logic       gravity_tick;
    logic       flap_tick;
    logic       spawn_tick;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    game_tick_scheduler #(
        .BASE_CYCLE(BC), .LEVEL_STEP(LS), .MAX_LEVEL(ML),
        .LVL_SCORE(LSC), .GRAV_DIV(GD), .SPAWN_DIV(SD)
    ) dut (
        .clk_in(clk_in), .reset_n(reset_n), .start(start), .flap(flap),
        .hit(hit), .point(point), .pause(pause), .state(state),
        .scroll_tick(scroll_tick), .gravity_tick(gravity_tick),
        .flap_tick(flap_tick), .spawn_tick(spawn_tick), .level(level)
    );

    always #5 clk_in = ~clk_in;

    // Model: a game is a count of RUN cycles toward the current period, a tick count and a point total.
    logic [1:0] e_state = 2'd0;
    logic [2:0] e_level = 3'd0;
    logic       e_scroll = 1'b0, e_grav = 1'b0, e_flap = 1'b0, e_spawn = 1'b0;
    int         m_elapsed = 0, m_period = BC, m_nticks = 0, m_points = 0;
    bit         m_pend = 1'b0;

    function automatic int lvl_of(input int pts);
        return (pts / LSC > ML) ? ML : pts / LSC;
    endfunction

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            e_state = 2'd0; e_level = 3'd0;
            e_scroll = 1'b0; e_grav = 1'b0; e_flap = 1'b0; e_spawn = 1'b0;
            m_elapsed = 0; m_period = BC; m_nticks = 0; m_points = 0; m_pend = 1'b0;
        end else begin
            int lv;
            lv = lvl_of(m_points);
            e_scroll = 1'b0; e_grav = 1'b0; e_flap = 1'b0; e_spawn = 1'b0;
            case (e_state)
                2'd0, 2'd3: begin
                    if (start) begin
                        e_state = 2'd1;
                        m_points = 0; m_nticks = 0; m_pend = 1'b0;
                        m_elapsed = 0; m_period = BC;
                    end
                end
                2'd1: begin
                    if (hit) begin
                        e_state = 2'd3;
                    end else begin
                        if (point) m_points++;
                        if (pause) begin
                            e_state = 2'd2;
                            if (flap) m_pend = 1'b1;
                        end else begin
                            m_elapsed++;
                            if (m_elapsed == m_period) begin
                                m_nticks++;
                                e_scroll = 1'b1;
                                if (m_pend || flap) begin
                                    e_flap = 1'b1;
                                    m_pend = 1'b0;
                                end else begin
                                    e_grav = (m_nticks % GD == 0);
                                end
                                e_spawn   = (m_nticks % SD == 0);
                                m_elapsed = 0;
                                m_period  = BC - lv * LS;
                            end else if (flap) begin
                                m_pend = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (!pause) e_state = 2'd1;
                end
            endcase
            e_level = 3'(lvl_of(m_points));
        end
    end

    always @(negedge clk_in) begin
        checks++;
        if ({state, level, scroll_tick, gravity_tick, flap_tick, spawn_tick} !==
            {e_state, e_level, e_scroll, e_grav, e_flap, e_spawn}) begin
            failures++;
            $display("FAIL model_cmp t=%0t actual st=%b lv=%0d sgfp=%b%b%b%b required st=%b lv=%0d sgfp=%b%b%b%b",
                     $time, state, level, scroll_tick, gravity_tick, flap_tick, spawn_tick,
                     e_state, e_level, e_scroll, e_grav, e_flap, e_spawn);
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_in);
        #1;
    endtask

    int scroll_at[$];

    initial begin
        reset_n = 1'b0;
        repeat (3) next_cycle();
        lit("reset_state", 32'(state), 0);
        lit("reset_level", 32'(level), 0);
        lit("reset_ticks", 32'({scroll_tick, gravity_tick, flap_tick, spawn_tick}), 0);
        reset_n = 1'b1;
        next_cycle();
        lit("idle_state", 32'(state), 0);

        // Game 1: base rhythm with a flap pulsed at cycle 13.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        lit("run_state", 32'(state), 1);
        for (int c = 1; c <= 62; c++) begin
            logic [3:0] exp4;
            next_cycle();
            flap = (c == 13);
            exp4 = {c % 10 == 0, c == 40 || c == 60, c == 20, c == 30 || c == 60};
            lit($sformatf("rhythm_c%0d", c),
                32'({scroll_tick, gravity_tick, flap_tick, spawn_tick}), 32'(exp4));
        end

        // Two points raise the level; the following period is 8.
        for (int c = 63; c <= 90; c++) begin
            next_cycle();
            point = (c == 63 || c == 65);
            if (c == 65) lit("level_one_point", 32'(level), 0);
            if (c == 66) lit("level_two_points", 32'(level), 1);
            lit($sformatf("lvl1_scroll_c%0d", c), 32'(scroll_tick),
                32'(c == 70 || c == 78 || c == 86));
        end

        // Eight more points saturate the level at 3; the period shrinks to 4.
        for (int c = 91; c <= 125; c++) begin
            next_cycle();
            point = (c >= 91 && c <= 105 && (c % 2 == 1));
            if (scroll_tick) scroll_at.push_back(c);
            if (c == 107) lit("level_saturated", 32'(level), 3);
        end
        lit("sat_scroll_count", 32'(scroll_at.size()), 7);
        if (scroll_at.size() == 7) begin
            lit("sat_scroll_0", 32'(scroll_at[0]), 94);
            lit("sat_scroll_1", 32'(scroll_at[1]), 102);
            lit("sat_scroll_2", 32'(scroll_at[2]), 106);
            lit("sat_scroll_5", 32'(scroll_at[5]), 118);
            lit("sat_scroll_6", 32'(scroll_at[6]), 122);
        end

        // Hit together with a point on the base-tick cycle 129.
        for (int c = 126; c <= 129; c++) begin
            next_cycle();
            if (c == 126) lit("pre_hit_scroll", 32'(scroll_tick), 1);
        end
        hit = 1'b1;
        point = 1'b1;
        next_cycle();
        hit = 1'b0;
        point = 1'b0;
        lit("hit_no_tick", 32'({scroll_tick, gravity_tick, flap_tick, spawn_tick}), 0);
        lit("hit_state", 32'(state), 3);
        lit("hit_level", 32'(level), 3);
        flap = 1'b1;
        point = 1'b1;
        next_cycle();
        flap = 1'b0;
        point = 1'b0;
        repeat (12) next_cycle();
        lit("over_state", 32'(state), 3);
        lit("over_level", 32'(level), 3);
        lit("over_ticks", 32'({scroll_tick, gravity_tick, flap_tick, spawn_tick}), 0);

        // Game 2: restart, pause from cycle 5 for 25 cycles, pause on a tick cycle at 55.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        lit("restart_state", 32'(state), 1);
        lit("restart_level", 32'(level), 0);
        for (int c = 1; c <= 62; c++) begin
            next_cycle();
            pause = (c >= 5 && c <= 29) || (c >= 55 && c <= 57);
            point = (c == 59 || c == 61);
            lit($sformatf("pause_state_c%0d", c), 32'(state),
                ((c >= 6 && c <= 30) || (c >= 56 && c <= 58)) ? 2 : 1);
            lit($sformatf("pause_scroll_c%0d", c), 32'(scroll_tick),
                32'(c == 36 || c == 46 || c == 60));
        end
        point = 1'b0;
        lit("pre_reset_level", 32'(level), 1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_n = 1'b0;
        #1;
        lit("async_reset_state", 32'(state), 0);
        lit("async_reset_level", 32'(level), 0);
        lit("async_reset_ticks", 32'({scroll_tick, gravity_tick, flap_tick, spawn_tick}), 0);
        next_cycle();
        reset_n = 1'b1;
        repeat (3) next_cycle();
        lit("post_reset_idle", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_tick_scheduler.md
# game_tick_scheduler

Timebase controller for the game loop: divides `clk_in` into a base game tick and shares that tick among the bird-gravity, pipe-scroll, pipe-spawn and flap consumers. It sequences the game through idle/run/pause/over and shortens the tick period as the score rises. It sits between the input/collision logic and the bird/pipe datapaths, and replaces free-running per-module dividers.

## Interface
- `BASE_CYCLE`, default 762: base tick period at level 0, in `clk_in` cycles.
- `LEVEL_STEP`, default 64: period reduction per level, in cycles.
- `MAX_LEVEL`, default 7: level saturation value; must be ≤7 and BASE_CYCLE − MAX_LEVEL·LEVEL_STEP ≥ 2.
- `LVL_SCORE`, default 5: points required per level increment.
- `GRAV_DIV`, default 2: base ticks per gravity slot.
- `SPAWN_DIV`, default 8: base ticks per pipe spawn.

Ports:
- `clk_in`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins or restarts a game.
- `flap`  in  1  pulse from the debounced button.
- `hit`  in  1  collision pulse.
- `point`  in  1  pipe-passed pulse.
- `pause`  in  1  level; high holds the game.
- `state`  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER.
- `scroll_tick`  out  1  one-cycle pulse on every base tick.
- `gravity_tick`  out  1  one-cycle pulse on a gravity slot.
- `flap_tick`  out  1  one-cycle pulse that grants a pending flap.
- `spawn_tick`  out  1  one-cycle pulse that requests a new pipe.
- `level`  out  3  current speed level.

## Operation
- All outputs are registered. Under reset: `state`=IDLE, all ticks 0, `level`=0, and all internal counters and the flap-pending flag cleared.
- State transitions, evaluated in priority order:
  - IDLE or OVER with `start` → RUN. This clears score, level, gravity/spawn counters and flap-pending, and loads the divider with P−1.
  - RUN with `hit` → OVER. `hit` has priority over `pause` and `point`.
  - RUN with `pause` → PAUSED.
  - PAUSED with !`pause` → RUN. This does not reload the divider.
  - `start` in RUN or PAUSED is ignored.
  - `hit` is ignored outside RUN.
- Period: P = BASE_CYCLE − level·LEVEL_STEP.
  - Divider `cnt` decrements on each RUN cycle.
  - The cycle with `cnt`==0 is the base-tick cycle; on that edge `cnt` reloads P−1 using the current `level`.
  - A level change mid-period takes effect at the next reload.
- PAUSED: every counter and the flap-pending flag are frozen and no ticks are issued. Resume continues from the exact frozen count.
- A base tick is issued only if state is RUN and `hit` is low that cycle. On an issued base tick the following outputs pulse on the next cycle:
  - `scroll_tick`: always.
  - Gravity slot: the gravity counter (mod GRAV_DIV) wraps on every GRAV_DIV-th base tick.
  - Flap arbitration (flap beats gravity): if flap-pending OR `flap` this cycle, `flap_tick`=1, `gravity_tick`=0 and flap-pending is cleared. A gravity slot suppressed by a flap is dropped, not deferred. Otherwise `gravity_tick`=1 on a gravity slot.
  - `spawn_tick`: spawn counter (mod SPAWN_DIV) wraps on every SPAWN_DIV-th base tick.
- `flap` in RUN on a non-tick cycle sets flap-pending. Multiple flaps between ticks merge into one grant. `flap` outside RUN is ignored.
- `point` in RUN with !`hit` increments the points-in-level counter. When it reaches LVL_SCORE it clears and `level` increments, saturating at MAX_LEVEL; the counter keeps clearing at saturation.

## Timing
- `start` sampled at edge k → `state`=RUN from edge k.
- With no pause, the first `scroll_tick` is high in the cycle after edge k+P and repeats every P cycles.
- Tick outputs rise one cycle after the base-tick cycle and are high for exactly one cycle.
- Multiple tick outputs may be high in the same cycle.
- `flap_tick` and `gravity_tick` are never high in the same cycle.
- `hit` in a base-tick cycle: no ticks are issued; `state`=OVER next cycle; all ticks stay 0 thereafter until restart.
- `pause` rising in a base-tick cycle: that tick is not issued; it issues one cycle after resume.
- `reset_n` low mid-game: outputs go to reset values immediately, without waiting for a clock edge.
- Divider width: $clog2(BASE_CYCLE) bits. Level arithmetic is unsigned and never underflows, given the parameter constraint.

## Test plan
All scenarios use BASE_CYCLE=10, LEVEL_STEP=2, MAX_LEVEL=3, LVL_SCORE=2, GRAV_DIV=2, SPAWN_DIV=3.
- Reset then `start` at edge 0 → `scroll_tick` pulses after edges 10, 20, 30…; `gravity_tick` on 2nd/4th ticks; `spawn_tick` on 3rd/6th ticks; `state`=01.
- `flap` pulsed at cycle 13 → `flap_tick` with the 2nd tick (after edge 20) and no `gravity_tick` then; the next gravity pulse is on the 4th tick.
- Two points → `level`=1 and the next period is 8 cycles. Eight points → `level` saturates at 3 with a period of 4.
- `pause` high for 25 cycles beginning at cycle 5 → no ticks while paused; the first tick comes 5 RUN cycles after release; the `state` sequence is 01→10→01.
- `hit` coincident with a base tick and with `point` → no tick, `level` unchanged, `state`=11. `flap` or `point` in OVER has no effect. `start` → RUN with `level`=0.
- `reset_n` asserted asynchronously mid-RUN → `state`=00 and all ticks/`level` read 0 before the next clock edge.
